seg_bus_responder: RTL and testbench

Display-side responder for the two-wire segment-display bus driven by the segment driver. It oversamples `seg_scl_i`/`sda_i` on the system clock and detects START/STOP. It receives LSB-first bytes, drives the ninth-clock ACK low, and decodes data-set, address-set and display-control commands into four digit registers and a control register. It is used as the on-board loopback target and as the synthesizable bus model in driver testbenches.

---
 rtl/seg_bus_responder.sv | 210 +++++++++++++++++++++
 tb/tb_seg_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bus_responder.sv
// seg_bus_responder: display-side responder for the two-wire segment bus.
// Oversamples SCL/SDA, detects START/STOP, receives LSB-first bytes, ACKs
// them and decodes commands into shadow digit/control registers that commit
// to the outputs on STOP.
module seg_bus_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 4
) (
  input  logic       clk_i,
  input  logic       sync_reset_i,
  input  logic       seg_scl_i,
  input  logic       sda_i,
  output logic       sda_out_o,
  output logic       sda_out_en_o,
  output logic [7:0] digits_o [NUM_DIGITS-1:0],
  output logic [3:0] ctrl_o,
  output logic       update_o,
  output logic       busy_o,
  output logic       cmd_error_o
);

  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_IGNORE} state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_rise_reg;
  logic                   scl_fall_reg;
  logic                   start_reg;
  logic                   stop_reg;
  logic                   sda_bit_reg;

  state_t                 state_reg;
  state_t                 after_ack_reg;
  logic [6:0]             shift_reg;
  logic [3:0]             bit_cnt_reg;
  logic                   ack_wait_reg;
  logic                   ack_en_reg;
  logic                   acked_any_reg;
  logic [PTR_W-1:0]       ptr_reg;
  logic [7:0]             shadow_reg [NUM_DIGITS-1:0];
  logic [3:0]             ctrl_shadow_reg;
  logic [7:0]             digits_reg [NUM_DIGITS-1:0];
  logic [3:0]             ctrl_reg;
  logic                   update_reg;
  logic                   busy_reg;
  logic                   cmd_error_reg;
  logic [7:0]             byte_next;

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  // Completed byte as it will look once the current bit is shifted in.
  assign byte_next = {sda_bit_reg, shift_reg};

  // Synchronizer chains; reset to the idle-high bus level so release is quiet.
  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], seg_scl_i};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
    end
  end

  // Edge detection, registered so bus events reach the FSM as clean pulses.
  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      sda_bit_reg  <= 1'b1;
    end else begin
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
      scl_rise_reg <= scl_s & ~scl_d_reg;
      scl_fall_reg <= ~scl_s & scl_d_reg;
      start_reg    <= scl_s & scl_d_reg & sda_d_reg & ~sda_s;
      stop_reg     <= scl_s & scl_d_reg & ~sda_d_reg & sda_s;
      sda_bit_reg  <= sda_s;
    end
  end

  // Protocol FSM: framing, byte reception, ACK, command decode and commit.
  always_ff @(posedge clk_i) begin
    if (sync_reset_i) begin
      state_reg       <= ST_IDLE;
      after_ack_reg   <= ST_IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      ack_wait_reg    <= 1'b0;
      ack_en_reg      <= 1'b0;
      acked_any_reg   <= 1'b0;
      ptr_reg         <= '0;
      ctrl_shadow_reg <= '0;
      ctrl_reg        <= '0;
      update_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      cmd_error_reg   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= '0;
        digits_reg[i] <= '0;
      end
    end else begin
      update_reg    <= 1'b0;
      cmd_error_reg <= 1'b0;
      if (start_reg) begin
        // START or repeated START: drop any frame in progress, reload shadows.
        state_reg       <= ST_CMD;
        busy_reg        <= 1'b1;
        bit_cnt_reg     <= '0;
        ack_wait_reg    <= 1'b0;
        ack_en_reg      <= 1'b0;
        acked_any_reg   <= 1'b0;
        ctrl_shadow_reg <= ctrl_reg;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          shadow_reg[i] <= digits_reg[i];
        end
      end else if (stop_reg) begin
        state_reg    <= ST_IDLE;
        busy_reg     <= 1'b0;
        bit_cnt_reg  <= '0;
        ack_wait_reg <= 1'b0;
        ack_en_reg   <= 1'b0;
        if (state_reg != ST_IDLE && acked_any_reg) begin
          update_reg <= 1'b1;
          ctrl_reg   <= ctrl_shadow_reg;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_reg[i] <= shadow_reg[i];
          end
        end
      end else if (state_reg == ST_CMD || state_reg == ST_DATA) begin
        if (ack_wait_reg) begin
          // First SCL fall pulls SDA low, the next one ends the ACK clock.
          if (scl_fall_reg) begin
            if (!ack_en_reg) begin
              ack_en_reg <= 1'b1;
            end else begin
              ack_en_reg   <= 1'b0;
              ack_wait_reg <= 1'b0;
              bit_cnt_reg  <= '0;
              state_reg    <= after_ack_reg;
            end
          end
        end else if (scl_rise_reg) begin
          shift_reg <= byte_next[7:1];
          if (bit_cnt_reg == 4'd7) begin
            bit_cnt_reg <= 4'd8;
            if (state_reg == ST_DATA) begin
              shadow_reg[ptr_reg] <= byte_next;
              ptr_reg             <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
              acked_any_reg       <= 1'b1;
              ack_wait_reg        <= 1'b1;
              after_ack_reg       <= ST_DATA;
            end else begin
              casez (byte_next)
                8'b0100_0000: begin
                  ack_wait_reg  <= 1'b1;
                  after_ack_reg <= ST_IGNORE;
                end
                8'b11??_????: begin
                  ptr_reg       <= byte_next[PTR_W-1:0];
                  ack_wait_reg  <= 1'b1;
                  after_ack_reg <= ST_DATA;
                end
                8'b10??_????: begin
                  ctrl_shadow_reg <= byte_next[3:0];
                  acked_any_reg   <= 1'b1;
                  ack_wait_reg    <= 1'b1;
                  after_ack_reg   <= ST_IGNORE;
                end
                default: begin
                  cmd_error_reg <= 1'b1;
                  state_reg     <= ST_IGNORE;
                end
              endcase
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digits_o[gi] = digits_reg[gi];
    end
  endgenerate

  assign sda_out_o    = 1'b0;
  assign sda_out_en_o = ack_en_reg;
  assign ctrl_o       = ctrl_reg;
  assign update_o     = update_reg;
  assign busy_o       = busy_reg;
  assign cmd_error_o  = cmd_error_reg;

endmodule

// File: tb/tb_seg_bus_responder.sv
// Directed testbench for seg_bus_responder: drives bus frames and checks
// ACKs, committed digits/control, pulses and reset behaviour.
module tb_seg_bus_responder;

  localparam int ND   = 4;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic       scl;
  logic       sda_drv;
  logic       sda_pad;
  logic       sda_out;
  logic       sda_out_en;
  logic [7:0] digits [ND-1:0];
  logic [3:0] ctrl;
  logic       update;
  logic       busy;
  logic       cmd_error;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int ack_cnt = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  // Open-drain resolution of the SDA pad.
  assign sda_pad = sda_out_en ? sda_out : sda_drv;

  seg_bus_responder #(.SYNC_STAGES(2), .NUM_DIGITS(ND)) dut (
    .clk_i        (clk),
    .sync_reset_i (sync_reset),
    .seg_scl_i    (scl),
    .sda_i        (sda_pad),
    .sda_out_o    (sda_out),
    .sda_out_en_o (sda_out_en),
    .digits_o     (digits),
    .ctrl_o       (ctrl),
    .update_o     (update),
    .busy_o       (busy),
    .cmd_error_o  (cmd_error)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
    if (cmd_error) err_cnt <= err_cnt + 1;
    if (sda_out_en && !en_prev) ack_cnt <= ack_cnt + 1;
    en_prev <= sda_out_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(3);
    sda_drv = b;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    wait_clk(3);
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF / 2);
    ack = sda_out_en;
    wait_clk(HALF - HALF / 2);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(3);
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(3);
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    sda_drv = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    scl = 1'b1;
    sda_drv = 1'b1;
    wait_clk(5);
    sync_reset = 1'b0;
    wait_clk(2);
    n_cmp++; if (sda_out_en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", sda_out_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (update !== 1'b0 || cmd_error !== 1'b0) begin n_bad++; $display("FAIL rst_pulses: got %b%b want 00", update, cmd_error); end
    n_cmp++; if (ctrl !== 4'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
    for (int i = 0; i < ND; i++) begin
      n_cmp++; if (digits[i] !== 8'h00) begin n_bad++; $display("FAIL rst_digit[%0d]: got %h want 00", i, digits[i]); end
    end
    $display("reset: done");
  endtask

  task automatic test_addr_write();
    logic [7:0] tx [5] = '{8'hC0, 8'h3F, 8'h06, 8'h5B, 8'h4F};
    logic [7:0] exp [ND] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
    logic ack;
    int upd0 = upd_cnt;
    int ack0 = ack_cnt;
    // START with busy latency check.
    wait_clk(3);
    sda_drv = 1'b0;
    wait_clk(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_early: got %b want 0", busy); end
    wait_clk(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b want 1", busy); end
    wait_clk(HALF - 4);
    scl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(tx[i], ack);
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL addr_ack[%0d]: got %b want 1", i, ack); end
    end
    // STOP with commit latency check.
    wait_clk(3);
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    sda_drv = 1'b1;
    wait_clk(3);
    n_cmp++; if (update !== 1'b0 || digits[0] !== 8'h00) begin n_bad++; $display("FAIL commit_early: got upd=%b d0=%h want 0/00", update, digits[0]); end
    wait_clk(1);
    n_cmp++; if (update !== 1'b1 || digits[0] !== 8'h3F) begin n_bad++; $display("FAIL commit_edge: got upd=%b d0=%h want 1/3f", update, digits[0]); end
    wait_clk(HALF);
    for (int i = 0; i < ND; i++) begin
      n_cmp++; if (digits[i] !== exp[i]) begin n_bad++; $display("FAIL addr_digit[%0d]: got %h want %h", i, digits[i], exp[i]); end
    end
    n_cmp++; if (upd_cnt - upd0 !== 1) begin n_bad++; $display("FAIL addr_updates: got %0d want 1", upd_cnt - upd0); end
    n_cmp++; if (ack_cnt - ack0 !== 5) begin n_bad++; $display("FAIL addr_acks: got %0d want 5", ack_cnt - ack0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL addr_busy_end: got %b want 0", busy); end
    $display("frame: C0 3F 06 5B 4F -> %h %h %h %h", digits[0], digits[1], digits[2], digits[3]);
  endtask

  task automatic test_wrap();
    logic [7:0] tx [4] = '{8'hC2, 8'h11, 8'h22, 8'h33};
    logic [7:0] exp [ND] = '{8'h33, 8'h06, 8'h11, 8'h22};
    logic ack;
    int upd0 = upd_cnt;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(tx[i], ack);
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL wrap_ack[%0d]: got %b want 1", i, ack); end
    end
    bus_stop();
    for (int i = 0; i < ND; i++) begin
      n_cmp++; if (digits[i] !== exp[i]) begin n_bad++; $display("FAIL wrap_digit[%0d]: got %h want %h", i, digits[i], exp[i]); end
    end
    n_cmp++; if (upd_cnt - upd0 !== 1) begin n_bad++; $display("FAIL wrap_updates: got %0d want 1", upd_cnt - upd0); end
    $display("frame: C2 11 22 33 -> %h %h %h %h", digits[0], digits[1], digits[2], digits[3]);
  endtask

  task automatic test_ctrl();
    logic ack;
    int upd0 = upd_cnt;
    bus_start();
    send_byte(8'h8F, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL ctrl_ack: got %b want 1", ack); end
    bus_stop();
    n_cmp++; if (ctrl !== 4'hF) begin n_bad++; $display("FAIL ctrl_value: got %h want f", ctrl); end
    n_cmp++; if (upd_cnt - upd0 !== 1) begin n_bad++; $display("FAIL ctrl_updates: got %0d want 1", upd_cnt - upd0); end
    n_cmp++; if (digits[1] !== 8'h06) begin n_bad++; $display("FAIL ctrl_digit1: got %h want 06", digits[1]); end
    $display("frame: 8F -> ctrl %h", ctrl);
  endtask

  task automatic test_bad_cmd();
    logic ack;
    int upd0 = upd_cnt;
    int err0 = err_cnt;
    bus_start();
    send_byte(8'h12, ack);
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL bad_ack: got %b want 0", ack); end
    bus_stop();
    n_cmp++; if (err_cnt - err0 !== 1) begin n_bad++; $display("FAIL bad_errors: got %0d want 1", err_cnt - err0); end
    n_cmp++; if (upd_cnt - upd0 !== 0) begin n_bad++; $display("FAIL bad_updates: got %0d want 0", upd_cnt - upd0); end
    n_cmp++; if (ctrl !== 4'hF) begin n_bad++; $display("FAIL bad_ctrl: got %h want f", ctrl); end
    $display("frame: 12 -> cmd_error count %0d", err_cnt - err0);
  endtask

  task automatic test_abort();
    logic [7:0] exp [ND] = '{8'h33, 8'h7F, 8'h11, 8'h22};
    logic ack;
    int upd0 = upd_cnt;
    bus_start();
    send_byte(8'hC0, ack);
    send_byte(8'h3F, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus_start();
    send_byte(8'hC1, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL abort_cmd_ack: got %b want 1", ack); end
    send_byte(8'h7F, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL abort_data_ack: got %b want 1", ack); end
    bus_stop();
    for (int i = 0; i < ND; i++) begin
      n_cmp++; if (digits[i] !== exp[i]) begin n_bad++; $display("FAIL abort_digit[%0d]: got %h want %h", i, digits[i], exp[i]); end
    end
    n_cmp++; if (upd_cnt - upd0 !== 1) begin n_bad++; $display("FAIL abort_updates: got %0d want 1", upd_cnt - upd0); end
    $display("frame: C0 3F <4b> Sr C1 7F -> %h %h %h %h", digits[0], digits[1], digits[2], digits[3]);
  endtask

  task automatic test_data_set_only();
    logic ack;
    int upd0 = upd_cnt;
    int ack0 = ack_cnt;
    bus_start();
    send_byte(8'h40, ack);
    n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL dset_ack: got %b want 1", ack); end
    bus_stop();
    n_cmp++; if (upd_cnt - upd0 !== 0) begin n_bad++; $display("FAIL dset_updates: got %0d want 0", upd_cnt - upd0); end
    n_cmp++; if (ack_cnt - ack0 !== 1) begin n_bad++; $display("FAIL dset_acks: got %0d want 1", ack_cnt - ack0); end
    n_cmp++; if (digits[1] !== 8'h7F || ctrl !== 4'hF) begin n_bad++; $display("FAIL dset_hold: got d1=%h ctrl=%h want 7f/f", digits[1], ctrl); end
    $display("frame: 40 -> no update");
  endtask

  task automatic test_reset_mid_ack();
    logic saw = 1'b0;
    logic [7:0] cmd = 8'hC0;
    bus_start();
    for (int i = 0; i < 8; i++) send_bit(cmd[i]);
    sda_drv = 1'b1;
    for (int i = 0; i < 20 && !saw; i++) begin
      wait_clk(1);
      saw = sda_out_en;
    end
    n_cmp++; if (saw !== 1'b1) begin n_bad++; $display("FAIL rstack_seen: got %b want 1", saw); end
    sync_reset = 1'b1;
    wait_clk(1);
    n_cmp++; if (sda_out_en !== 1'b0) begin n_bad++; $display("FAIL rstack_en: got %b want 0", sda_out_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstack_busy: got %b want 0", busy); end
    n_cmp++; if (ctrl !== 4'h0) begin n_bad++; $display("FAIL rstack_ctrl: got %h want 0", ctrl); end
    for (int i = 0; i < ND; i++) begin
      n_cmp++; if (digits[i] !== 8'h00) begin n_bad++; $display("FAIL rstack_digit[%0d]: got %h want 00", i, digits[i]); end
    end
    sync_reset = 1'b0;
    wait_clk(3);
    scl = 1'b1;
    wait_clk(HALF);
    $display("reset mid-ACK: outputs cleared");
  endtask

  initial begin
    sync_reset = 1'b1;
    scl = 1'b1;
    sda_drv = 1'b1;
    test_reset();
    test_addr_write();
    test_wrap();
    test_ctrl();
    test_bad_cmd();
    test_abort();
    test_data_set_only();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
